pad_ctrl: RTL
=============

PAD_CTRL -- requirements
Module: pad_ctrl

Interface
REQ-001 The block SHALL have parameter NPAD, default 8, meaning the number of controlled stdiocell pads.
REQ-002 The block SHALL have parameter DB_LIMIT, default 15, meaning debounce stability count in clk cycles (used only with PAD_CTRL_DEBOUNCE_EN).
REQ-003 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 The block SHALL have port sel  input  1  register access strobe.
REQ-006 The block SHALL have port we  input  1  write enable, qualified by sel.
REQ-007 The block SHALL have port addr  input  3  register index.
REQ-008 The block SHALL have port wdata  input  NPAD  write data.
REQ-009 The block SHALL have port rdata  output  NPAD  registered read data.
REQ-010 The block SHALL have port alt_dout  input  NPAD  alternate-function output data.
REQ-011 The block SHALL have port alt_oe  input  NPAD  alternate-function output enable.
REQ-012 The block SHALL have port alt_di  output  NPAD  conditioned pad input to alternate function.
REQ-013 The block SHALL have ports pad_dout, pad_oe, pad_ie, pad_puen  output  NPAD each  to stdiocell dout/oe/ie/puen.
REQ-014 The block SHALL have port pad_di  input  NPAD  from stdiocell di (asynchronous).
REQ-015 The block SHALL have port irq  output  1  level interrupt.

Function
REQ-016 Register map SHALL be: 0 DOUT, 1 OE, 2 IE, 3 PUEN, 4 ALTSEL, 5 IN (read-only), 6 IRQEN, 7 IRQPEND (write-1-to-clear).
REQ-017 A write (sel=1, we=1) SHALL update the addressed register at the same clk edge; writes to IN SHALL be ignored.
REQ-018 A read (sel=1, we=0) SHALL present the addressed register on rdata one cycle later; rdata SHALL hold its value when no read occurs.
REQ-019 Per pin i, pad_dout[i]/pad_oe[i] SHALL equal alt_dout[i]/alt_oe[i] when ALTSEL[i]=1, else DOUT[i]/OE[i]; combinational, zero latency.
REQ-020 pad_ie and pad_puen SHALL be driven directly from IE and PUEN regardless of ALTSEL.
REQ-021 pad_di SHALL pass through a two-flop synchronizer; IN SHALL reflect the synchronized (and, if enabled, debounced) value, 2 cycles latency without debounce.
REQ-022 alt_di SHALL equal IN.
REQ-023 A 0->1 transition of IN[i] SHALL set IRQPEND[i] the cycle after the transition is seen, independent of IRQEN.
REQ-024 Writing 1 to IRQPEND[i] SHALL clear it; a simultaneous set and clear on the same bit SHALL leave the bit set.
REQ-025 irq SHALL be registered and equal OR of (IRQPEND & IRQEN), one cycle after either changes.
REQ-026 Addresses outside 0..7 do not exist (3-bit addr); all accesses SHALL be fully decoded.

Reset
REQ-027 On rst=1 all registers, synchronizer flops, debounce counters, rdata and irq SHALL clear to 0 immediately without clk.
REQ-028 Outputs after reset SHALL be: pad_oe=0 (all pads Hi-Z), pad_ie=0, pad_puen=0, pad_dout=0, rdata=0, irq=0, alt_di=0.
REQ-029 Reset asserted mid-debounce or with pending interrupts SHALL discard all state; no edge SHALL be reported for the reset-induced IN change.

Configuration
REQ-030 With PAD_CTRL_DEBOUNCE_EN defined, each pin SHALL have a counter; IN[i] SHALL update to the synchronized value only after it differs from IN[i] for DB_LIMIT consecutive cycles; any reversion SHALL reset the counter to 0.
REQ-031 Without PAD_CTRL_DEBOUNCE_EN, no counters SHALL exist and IN SHALL equal the synchronizer output directly; DB_LIMIT SHALL be unused.

Verification
REQ-032 Write OE=0x0F, DOUT=0xA5 -> pad_oe=0x0F, pad_dout=0xA5 next cycle; read addr 1 -> rdata=0x0F one cycle after the read.
REQ-033 ALTSEL=0x01, alt_dout=0x01, alt_oe=0x01, DOUT=0x00 -> pad_dout[0]=1, pad_oe[0]=1; other pins follow DOUT/OE.
REQ-034 IE=0xFF, IRQEN=0x04, pad_di[2] 0->1 (no debounce) -> IN[2]=1 after 2 cycles, IRQPEND=0x04, irq=1 one cycle later; write IRQPEND=0x04 -> irq=0.
REQ-035 Second rising edge on pin 2 in same cycle as IRQPEND W1C of 0x04 -> IRQPEND[2] stays 1, irq stays 1.
REQ-036 With PAD_CTRL_DEBOUNCE_EN, DB_LIMIT=15: 10-cycle pulse on pad_di[3] -> IN[3] stays 0, no pending; 20-cycle level -> IN[3]=1 after 2+15 cycles.
REQ-037 rst pulse while IRQPEND=0xFF, OE=0xFF -> irq, pad_oe, IRQPEND all 0 before next clk edge.

Source files
------------

// File: rtl/pad_ctrl.sv
// Register-mapped controller for NPAD stdiocell pads: output/alternate muxing, synchronized input,
// rising-edge interrupts. Define PAD_CTRL_DEBOUNCE_EN to add per-pin input debounce counters.
module pad_ctrl #(
  parameter int NPAD     = 8,
  parameter int DB_LIMIT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sel,
  input  logic            we,
  input  logic [2:0]      addr,
  input  logic [NPAD-1:0] wdata,
  output logic [NPAD-1:0] rdata,
  input  logic [NPAD-1:0] alt_dout,
  input  logic [NPAD-1:0] alt_oe,
  output logic [NPAD-1:0] alt_di,
  output logic [NPAD-1:0] pad_dout,
  output logic [NPAD-1:0] pad_oe,
  output logic [NPAD-1:0] pad_ie,
  output logic [NPAD-1:0] pad_puen,
  input  logic [NPAD-1:0] pad_di,
  output logic            irq
);

  logic [NPAD-1:0] dout_reg, oe_reg, ie_reg, puen_reg, altsel_reg, irqen_reg;
  logic [NPAD-1:0] irqpend_reg, irqpend_next;
  logic [NPAD-1:0] sync1_reg, sync2_reg, in_val, in_prev_reg;
  logic [NPAD-1:0] rdata_reg, rd_mux, clr_mask;
  logic            irq_reg;
  logic            wr_en, rd_en;

  assign wr_en = sel & we;
  assign rd_en = sel & ~we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_reg   <= '0;
      oe_reg     <= '0;
      ie_reg     <= '0;
      puen_reg   <= '0;
      altsel_reg <= '0;
      irqen_reg  <= '0;
    end else if (wr_en) begin
      case (addr)
        3'd0: dout_reg   <= wdata;
        3'd1: oe_reg     <= wdata;
        3'd2: ie_reg     <= wdata;
        3'd3: puen_reg   <= wdata;
        3'd4: altsel_reg <= wdata;
        3'd6: irqen_reg  <= wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= pad_di;
      sync2_reg <= sync1_reg;
    end
  end

`ifdef PAD_CTRL_DEBOUNCE_EN
  localparam int CW = (DB_LIMIT < 2) ? 1 : $clog2(DB_LIMIT);

  // IN only follows the synchronizer after DB_LIMIT consecutive disagreeing cycles.
  for (genvar gi = 0; gi < NPAD; gi++) begin : g_db
    logic [CW-1:0] cnt_reg;
    logic          in_bit_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_reg    <= '0;
        in_bit_reg <= 1'b0;
      end else if (sync2_reg[gi] == in_bit_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(DB_LIMIT - 1)) begin
        cnt_reg    <= '0;
        in_bit_reg <= sync2_reg[gi];
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end

    assign in_val[gi] = in_bit_reg;
  end
`else
  assign in_val = sync2_reg;
`endif

  // A rising edge sets the pending bit even when the same bit is being cleared.
  assign clr_mask     = (wr_en && addr == 3'd7) ? wdata : '0;
  assign irqpend_next = (irqpend_reg & ~clr_mask) | (in_val & ~in_prev_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_prev_reg <= '0;
      irqpend_reg <= '0;
      irq_reg     <= 1'b0;
    end else begin
      in_prev_reg <= in_val;
      irqpend_reg <= irqpend_next;
      irq_reg     <= |(irqpend_reg & irqen_reg);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      3'd0: rd_mux = dout_reg;
      3'd1: rd_mux = oe_reg;
      3'd2: rd_mux = ie_reg;
      3'd3: rd_mux = puen_reg;
      3'd4: rd_mux = altsel_reg;
      3'd5: rd_mux = in_val;
      3'd6: rd_mux = irqen_reg;
      3'd7: rd_mux = irqpend_reg;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rdata_reg <= '0;
    else if (rd_en) rdata_reg <= rd_mux;
  end

  for (genvar gi = 0; gi < NPAD; gi++) begin : g_pad
    assign pad_dout[gi] = altsel_reg[gi] ? alt_dout[gi] : dout_reg[gi];
    assign pad_oe[gi]   = altsel_reg[gi] ? alt_oe[gi]   : oe_reg[gi];
  end

  assign pad_ie   = ie_reg;
  assign pad_puen = puen_reg;
  assign alt_di   = in_val;
  assign rdata    = rdata_reg;
  assign irq      = irq_reg;

endmodule
